// File: rtl/stack_writer.sv
// ---------------------------------------------------------------------------
// stack_writer
//
// Write-back sequencer for the 6502 core. It takes one write request per
// instruction from execute (plain store, stack push of 1/2/3 bytes, or
// read-modify-write) and turns it into single-byte memory write cycles. It
// also reports the stack pointer left behind by the pushes.
//
// Build option:
//   STACK_WRITER_RMW_DUMMY_EN  When defined, RMW performs the 6502 double
//                              write (old_data, then data_in) to addr_in.
//                              When undefined, RMW behaves as a plain STORE
//                              and old_data is ignored.
//
// Ports:
//   phi1        clock; all state changes on the rising edge
//   reset       synchronous, active-high reset
//   write_req   request strobe, sampled only while idle
//   write_kind  0 STORE, 1 PUSH1, 2 PUSH_PC, 3 PUSH_BRK, 4 RMW, 5-7 reserved
//   addr_in     target address for STORE/RMW
//   data_in     byte for STORE/PUSH1; new value for RMW
//   old_data    original value for the RMW dummy write
//   pc          return address for PUSH_PC/PUSH_BRK
//   status      P register for PUSH_BRK
//   sp          current stack pointer
//   busy        high from the cycle after accept through the DONE cycle
//   write_en    memory write strobe, one byte per cycle
//   addr        write address (holds its value while write_en is low)
//   data_out    write data (holds its value while write_en is low)
//   sp_next     stack pointer after pushes (registered)
//   write_done  one-cycle completion pulse
// ---------------------------------------------------------------------------
module stack_writer #(
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  phi1,
    input  logic                  reset,
    input  logic                  write_req,
    input  logic [2:0]            write_kind,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [REG_WIDTH-1:0]  data_in,
    input  logic [REG_WIDTH-1:0]  old_data,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [REG_WIDTH-1:0]  status,
    input  logic [REG_WIDTH-1:0]  sp,
    output logic                  busy,
    output logic                  write_en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [REG_WIDTH-1:0]  data_out,
    output logic [REG_WIDTH-1:0]  sp_next,
    output logic                  write_done
);

    localparam logic [2:0] KIND_STORE    = 3'd0;
    localparam logic [2:0] KIND_PUSH1    = 3'd1;
    localparam logic [2:0] KIND_PUSH_PC  = 3'd2;
    localparam logic [2:0] KIND_PUSH_BRK = 3'd3;
    localparam logic [2:0] KIND_RMW      = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] STACK_BASE = ADDR_WIDTH'(16'h0100);
    localparam logic [REG_WIDTH-1:0]  SP_RESET   = REG_WIDTH'(8'hFD);
    // B and unused bits are forced high in the status byte pushed by BRK.
    localparam logic [REG_WIDTH-1:0]  BRK_BITS   = REG_WIDTH'(8'h30);
    localparam logic [REG_WIDTH-1:0]  ONE        = REG_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    // Byte list built from the request inputs while idle.
    logic [2:0][REG_WIDTH-1:0] new_bytes;
    logic [1:0]                new_count;
    logic                      new_push;

    // Latched request: the bytes still to be written and how to address them.
    logic [2:0][REG_WIDTH-1:0] bytes_q;
    logic [1:0]                count_q;
    logic                      push_q;

    logic [REG_WIDTH-1:0]      ptr;
    logic [REG_WIDTH-1:0]      ptr_dec;
    logic [1:0]                idx;
    logic [1:0]                nxt_idx;
    logic                      last_byte;
    logic                      accept;

    // The stack page is fixed: the pointer is ORed into the low byte, so a
    // wrapped pointer stays on page 1 instead of carrying into page 2.
    function automatic logic [ADDR_WIDTH-1:0] stack_addr(input logic [REG_WIDTH-1:0] p);
        return STACK_BASE | ADDR_WIDTH'(p);
    endfunction

`ifndef STACK_WRITER_RMW_DUMMY_EN
    logic unused_old_data;
    assign unused_old_data = ^old_data;
`endif

    assign accept    = (state == IDLE) && write_req;
    assign ptr_dec   = ptr - ONE;
    assign nxt_idx   = idx + 2'd1;
    assign last_byte = (nxt_idx == count_q);

    assign busy       = (state != IDLE);
    assign write_en   = (state == WRITE);
    assign write_done = (state == DONE);

    // Translate the request into an ordered list of bytes.
    always_comb begin
        // NOTE: every always_comb output gets a default before the case, so no
        // path leaves a signal unassigned and no latch is inferred.
        new_bytes = '0;
        new_count = 2'd0;
        new_push  = 1'b0;
        case (write_kind)
            KIND_STORE: begin
                new_bytes[0] = data_in;
                new_count    = 2'd1;
            end
            KIND_PUSH1: begin
                new_bytes[0] = data_in;
                new_count    = 2'd1;
                new_push     = 1'b1;
            end
            KIND_PUSH_PC: begin
                new_bytes[0] = pc[2*REG_WIDTH-1:REG_WIDTH];
                new_bytes[1] = pc[REG_WIDTH-1:0];
                new_count    = 2'd2;
                new_push     = 1'b1;
            end
            KIND_PUSH_BRK: begin
                new_bytes[0] = pc[2*REG_WIDTH-1:REG_WIDTH];
                new_bytes[1] = pc[REG_WIDTH-1:0];
                new_bytes[2] = status | BRK_BITS;
                new_count    = 2'd3;
                new_push     = 1'b1;
            end
            KIND_RMW: begin
`ifdef STACK_WRITER_RMW_DUMMY_EN
                // 6502 bus behaviour: unmodified value first, then the result.
                new_bytes[0] = old_data;
                new_bytes[1] = data_in;
                new_count    = 2'd2;
`else
                new_bytes[0] = data_in;
                new_count    = 2'd1;
`endif
            end
            default: begin
                // Reserved kinds: accepted, but no bytes are written.
            end
        endcase
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (write_req) begin
                    next_state = (new_count == 2'd0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (last_byte) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge phi1) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the values from before the edge, independent of statement order.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request latch.
    always_ff @(posedge phi1) begin
        // NOTE: this is pure data storage, only read while WRITE is active, so
        // it has no reset; the control state that qualifies it is reset.
        if (accept) begin
            bytes_q <= new_bytes;
            count_q <= new_count;
            push_q  <= new_push;
        end
    end

    // Write sequencing: bus outputs, stack pointer and byte index.
    always_ff @(posedge phi1) begin
        if (reset) begin
            addr     <= '0;
            data_out <= '0;
            sp_next  <= SP_RESET;
            ptr      <= '0;
            idx      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (write_req) begin
                        ptr <= sp;
                        idx <= 2'd0;
                        // Reserved kinds leave the bus outputs untouched.
                        if (new_count != 2'd0) begin
                            addr     <= new_push ? stack_addr(sp) : addr_in;
                            data_out <= new_bytes[0];
                        end
                    end
                end
                WRITE: begin
                    if (push_q) begin
                        ptr     <= ptr_dec;
                        sp_next <= ptr_dec;
                    end
                    // Store/RMW bytes reuse the address already on the bus.
                    if (!last_byte) begin
                        idx      <= nxt_idx;
                        data_out <= bytes_q[nxt_idx];
                        if (push_q) begin
                            addr <= stack_addr(ptr_dec);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_writer.sv
`timescale 1ns/1ps
module tb_stack_writer;

    logic        phi1 = 1'b0;
    logic        reset = 1'b1;
    logic        write_req = 1'b0;
    logic [2:0]  write_kind = 3'd0;
    logic [15:0] addr_in = 16'h0000;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  old_data = 8'h00;
    logic [15:0] pc = 16'h0000;
    logic [7:0]  status = 8'h00;
    logic [7:0]  sp = 8'hFD;
    logic        busy;
    logic        write_en;
    logic [15:0] addr;
    logic [7:0]  data_out;
    logic [7:0]  sp_next;
    logic        write_done;

    stack_writer dut (
        .phi1       (phi1),
        .reset      (reset),
        .write_req  (write_req),
        .write_kind (write_kind),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .old_data   (old_data),
        .pc         (pc),
        .status     (status),
        .sp         (sp),
        .busy       (busy),
        .write_en   (write_en),
        .addr       (addr),
        .data_out   (data_out),
        .sp_next    (sp_next),
        .write_done (write_done)
    );

    always #5 phi1 = ~phi1;

    int cyc = 0;
    always @(posedge phi1) cyc++;

    typedef struct {
        int          cyc;
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    typedef struct {
        int         cyc;
        logic [7:0] sp;
    } done_t;

    wr_t   exp_wr[$];
    done_t exp_done[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Stack pointer the driver expects the design to report after each request.
    logic [7:0] drv_sp = 8'hFD;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit         mon_on = 1'b0;
    bit         rst_seen = 1'b0;
    logic [15:0] last_addr = 16'h0000;
    logic [7:0]  last_data = 8'h00;
    logic [7:0]  sp_idle = 8'hFD;

    always @(negedge phi1) begin
        if (mon_on) begin
            if (rst_seen) begin
                last_addr = 16'h0000;
                last_data = 8'h00;
                sp_idle   = 8'hFD;
            end
            if (write_en === 1'b1) begin
                check("busy_in_write", 32'(busy), 32'd1);
                if (exp_wr.size() == 0) begin
                    check("unexpected_write_addr", 32'(addr), 32'hFFFF_FFFF);
                    last_addr = addr;
                    last_data = data_out;
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("write_cycle", 32'(cyc), 32'(e.cyc));
                    check("write_addr", 32'(addr), 32'(e.a));
                    check("write_data", 32'(data_out), 32'(e.d));
                    last_addr = e.a;
                    last_data = e.d;
                end
            end else begin
                check("addr_hold", 32'(addr), 32'(last_addr));
                check("data_hold", 32'(data_out), 32'(last_data));
            end
            if (write_done === 1'b1) begin
                check("busy_in_done", 32'(busy), 32'd1);
                check("write_en_in_done", 32'(write_en), 32'd0);
                if (exp_done.size() == 0) begin
                    check("unexpected_done_cycle", 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    done_t e;
                    e = exp_done.pop_front();
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                    check("done_sp_next", 32'(sp_next), 32'(e.sp));
                    sp_idle = e.sp;
                end
            end
            if (busy === 1'b0) begin
                check("sp_next_idle", 32'(sp_next), 32'(sp_idle));
            end
            while (exp_wr.size() > 0 && exp_wr[0].cyc < cyc) begin
                check("missing_write_cycle", 32'hFFFF_FFFF, 32'(exp_wr[0].cyc));
                void'(exp_wr.pop_front());
            end
            while (exp_done.size() > 0 && exp_done[0].cyc < cyc) begin
                check("missing_done_cycle", 32'hFFFF_FFFF, 32'(exp_done[0].cyc));
                void'(exp_done.pop_front());
            end
        end
        rst_seen = reset;
    end

    // ---------------- driver with reference model ----------------
    // Called at #1 after a rising edge. Issues one request, optionally pulses
    // write_req again while busy, and returns in the first cycle where a new
    // request may be accepted (plus 'gap' idle cycles).
    task automatic issue(input logic [2:0] k, input logic [15:0] a, input logic [7:0] d,
                         input logic [7:0] od, input logic [15:0] p, input logic [7:0] st,
                         input logic [7:0] s, input bit pulse, input int gap);
        logic [7:0] b[$];
        bit         push;
        int         c;
        int         n;
        wr_t        w;
        done_t      dn;
        write_kind = k;
        addr_in    = a;
        data_in    = d;
        old_data   = od;
        pc         = p;
        status     = st;
        sp         = s;
        write_req  = 1'b1;
        c = cyc;
        push = 1'b0;
        b = {};
        case (k)
            3'd0: b.push_back(d);
            3'd1: begin b.push_back(d); push = 1'b1; end
            3'd2: begin b.push_back(p[15:8]); b.push_back(p[7:0]); push = 1'b1; end
            3'd3: begin
                b.push_back(p[15:8]); b.push_back(p[7:0]); b.push_back(st | 8'h30);
                push = 1'b1;
            end
            3'd4: begin
`ifdef STACK_WRITER_RMW_DUMMY_EN
                b.push_back(od); b.push_back(d);
`else
                b.push_back(d);
`endif
            end
            default: begin end
        endcase
        n = b.size();
        for (int i = 0; i < n; i++) begin
            w.cyc = c + 1 + i;
            w.a   = push ? (16'h0100 + 16'((int'(s) - i) & 255)) : a;
            w.d   = b[i];
            exp_wr.push_back(w);
        end
        if (push) drv_sp = 8'((int'(s) - n) & 255);
        dn.cyc = c + 1 + n;
        dn.sp  = drv_sp;
        exp_done.push_back(dn);
        @(posedge phi1); #1;
        write_req = pulse;
        if (pulse) begin
            write_kind = 3'($urandom);
            addr_in    = 16'($urandom);
            data_in    = 8'($urandom);
            old_data   = 8'($urandom);
            pc         = 16'($urandom);
            status     = 8'($urandom);
            sp         = 8'($urandom);
        end
        for (int i = 0; i < n + 1; i++) begin
            @(posedge phi1); #1;
            write_req = 1'b0;
        end
        repeat (gap) begin
            @(posedge phi1); #1;
        end
    endtask

    task automatic reset_mid_push_pc(input logic [7:0] s, input logic [15:0] p);
        wr_t w;
        write_kind = 3'd2;
        pc         = p;
        sp         = s;
        write_req  = 1'b1;
        w.cyc = cyc + 1;
        w.a   = 16'h0100 + 16'(s);
        w.d   = p[15:8];
        exp_wr.push_back(w);
        @(posedge phi1); #1;
        write_req = 1'b0;
        reset     = 1'b1;
        @(posedge phi1); #1;
        reset  = 1'b0;
        drv_sp = 8'hFD;
        @(negedge phi1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_write_en", 32'(write_en), 32'd0);
        check("midrst_write_done", 32'(write_done), 32'd0);
        check("midrst_addr", 32'(addr), 32'd0);
        check("midrst_data", 32'(data_out), 32'd0);
        check("midrst_sp_next", 32'(sp_next), 32'hFD);
        repeat (2) begin
            @(posedge phi1); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  k;
        logic [7:0]  s;
        bit          is_push;

        // Reset, with a request presented in the last reset cycle: it is lost.
        @(posedge phi1); #1;
        mon_on = 1'b1;
        @(negedge phi1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_write_en", 32'(write_en), 32'd0);
        check("rst_write_done", 32'(write_done), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_sp_next", 32'(sp_next), 32'hFD);
        @(posedge phi1); #1;
        write_kind = 3'd0;
        addr_in    = 16'h0300;
        data_in    = 8'hEE;
        write_req  = 1'b1;
        @(posedge phi1); #1;
        reset     = 1'b0;
        write_req = 1'b0;
        repeat (2) begin
            @(posedge phi1); #1;
        end

        // Directed cases.
        issue(3'd0, 16'h0200, 8'h5A, 8'h00, 16'h0000, 8'h00, drv_sp, 1'b0, 1);
        issue(3'd2, 16'h0000, 8'h00, 8'h00, 16'hC123, 8'h00, 8'hFD, 1'b0, 1);
        issue(3'd3, 16'h0000, 8'h00, 8'h00, 16'hE456, 8'h83, 8'h01, 1'b1, 0);
        issue(3'd4, 16'h0010, 8'h80, 8'h7F, 16'h0000, 8'h00, drv_sp, 1'b0, 0);
        issue(3'd6, 16'h1234, 8'h11, 8'h22, 16'h3344, 8'h55, drv_sp, 1'b1, 0);
        issue(3'd1, 16'h0000, 8'hA5, 8'h00, 16'h0000, 8'h00, 8'h00, 1'b0, 1);
        reset_mid_push_pc(8'hFD, 16'hBEEF);
        issue(3'd1, 16'h0000, 8'h3C, 8'h00, 16'h0000, 8'h00, drv_sp, 1'b0, 1);

        // Randomized traffic.
        for (int t = 0; t < 300; t++) begin
            k = 3'($urandom_range(0, 7));
            is_push = (k == 3'd1) || (k == 3'd2) || (k == 3'd3);
            s = (is_push && $urandom_range(0, 1) == 1) ? 8'($urandom) : drv_sp;
            issue(k, 16'($urandom), 8'($urandom), 8'($urandom), 16'($urandom),
                  8'($urandom), s, $urandom_range(0, 3) == 0, $urandom_range(0, 2));
        end

        repeat (4) begin
            @(posedge phi1); #1;
        end
        check("pending_writes", 32'(exp_wr.size()), 32'd0);
        check("pending_dones", 32'(exp_done.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stack_writer.md
# stack_writer

Memory write-back unit for the 6502 core, the write-side counterpart of the instruction fetcher. It takes one write request per instruction from execute: plain store, stack push of 1, 2 or 3 bytes, or read-modify-write. It sequences these into single-byte memory write cycles and reports the updated stack pointer. It sits between the execute stage and the memory bus arbiter.

## Interface
- REG_WIDTH, `REG_WIDTH (8): data and stack pointer width
- ADDR_WIDTH, `ADDR_WIDTH (16): address width
- phi1  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- write_req  in  1  request strobe; sampled only in IDLE
- write_kind  in  3  0 STORE, 1 PUSH1, 2 PUSH_PC, 3 PUSH_BRK, 4 RMW, 5-7 reserved
- addr_in  in  ADDR_WIDTH  target address for STORE/RMW
- data_in  in  REG_WIDTH  byte for STORE/PUSH1; new value for RMW
- old_data  in  REG_WIDTH  original value for RMW dummy write
- pc  in  ADDR_WIDTH  return address for PUSH_PC/PUSH_BRK
- status  in  REG_WIDTH  P register for PUSH_BRK
- sp  in  REG_WIDTH  current stack pointer
- busy  out  1  high from the cycle after accept through the DONE cycle
- write_en  out  1  memory write strobe, one byte per cycle
- addr  out  ADDR_WIDTH  write address
- data_out  out  REG_WIDTH  write data
- sp_next  out  REG_WIDTH  stack pointer after pushes
- write_done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, WRITE, DONE.
- IDLE with write_req=1 is an accept:
  - latch kind, addr_in, data_in, old_data, pc, status; load ptr <= sp
  - build the byte list: STORE {data_in@addr_in}; PUSH1 {data_in}; PUSH_PC {pc[15:8], pc[7:0]}; PUSH_BRK {pc[15:8], pc[7:0], status|8'h30}; RMW per Configuration
  - go to WRITE.
- WRITE emits one byte per cycle with write_en=1:
  - push bytes go to addr = `STACK_BASE + ptr, then ptr <= ptr - 1 mod 256
  - store and RMW bytes go to the latched address and leave ptr unchanged.
- After the last byte, go to DONE. In DONE: write_done=1, write_en=0, sp_next = final ptr. Then return to IDLE.
- Reserved kinds: accept, emit no writes, go straight to DONE. sp_next is unchanged.
- sp_next is registered. It updates after each push write and holds its value while IDLE.
- write_req while busy is ignored, not queued.
- When write_en=0, addr and data_out hold their last values.

## Timing
- Request accepted on the edge ending cycle N:
  - STORE/PUSH1: write in N+1, done in N+2
  - PUSH_PC: writes N+1..N+2, done N+3
  - PUSH_BRK: writes N+1..N+3, done N+4
- A new accept is possible in the cycle after DONE. Minimum spacing is 1 + bytes + 1 cycles.
- Stack wrap: ptr 8'h00 decrements to 8'hFF. Push addresses always stay in 16'h0100-16'h01FF and never carry into page 2.
- Reset values: state IDLE, busy 0, write_en 0, write_done 0, addr 0, data_out 0, sp_next 8'hFD.
- Reset mid-sequence: at the next edge all outputs take their reset values. Remaining bytes are dropped and no write_done is issued.
- Reset and write_req in the same cycle: reset wins and the request is lost.

## Configuration
- STACK_WRITER_RMW_DUMMY_EN defined: RMW emits two writes to addr_in.
  - first old_data in N+1, then data_in in N+2, done N+3
  - this matches 6502 double-write bus behaviour.
- Undefined: RMW is identical to STORE, a single write of data_in in N+1 with done in N+2. old_data is unused.

## Test plan
- Reset, then STORE addr_in=16'h0200 data_in=8'h5A -> write_en N+1 at 16'h0200/8'h5A; write_done N+2; sp_next stays 8'hFD.
- PUSH_PC sp=8'hFD pc=16'hC123 -> writes 16'h01FD=8'hC1, 16'h01FC=8'h23; done N+3; sp_next=8'hFB.
- PUSH_BRK sp=8'h01 status=8'h83 -> writes 16'h0101=PCH, 16'h0100=PCL, 16'h01FF=8'hB3; sp_next=8'hFE (wrap).
- RMW addr_in=16'h0010 old_data=8'h7F data_in=8'h80 -> with macro: 8'h7F then 8'h80 at 16'h0010, done N+3; without macro: a single 8'h80 write, done N+2.
- write_req pulsed during PUSH_BRK -> ignored: exactly 3 writes and 1 done; a req on the cycle after DONE is accepted.
- reset asserted in the second cycle of PUSH_PC -> no second write, no write_done, sp_next=8'hFD next cycle.
